// File: rtl/wb_pkg.sv
// Shared types and defaults for the write-back stage.
package wb_pkg;
  typedef enum logic {IDLE, WAIT_LOAD} wb_state_t;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 4;
endpackage

// File: rtl/wb_wait_timer.sv
// Load wait counter: load-1 on request, count while waiting, flag at TIMEOUT.
module wb_wait_timer import wb_pkg::*; #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load1,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (load1) cnt <= CW'(1);
    else if (en)    cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CW'(TIMEOUT));
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers retiring ALU/load results onto the regfile write
// port, stalls upstream while a load is outstanding, counts retirements.
module wb_stage import wb_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_wb_en,
  input  logic              mem_mem_r,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_alu_res,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_rvalid,
  output logic              WB_WB_EN,
  output logic [DATA_W-1:0] WB_Value,
  output logic [REG_AW-1:0] WB_Dest,
  output logic              stall,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic              timeout_err
);
  wb_state_t         state, nxt_state;
  logic              nxt_en, cnt_inc, set_err, pend_ld, tmr_load, tmr_en, expired;
  logic [DATA_W-1:0] nxt_val;
  logic [REG_AW-1:0] nxt_dest, pend_dest;
  logic              pend_wb;

  wb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load1   (tmr_load),
    .en      (tmr_en),
    .expired (expired)
  );

  always_comb begin
    nxt_state = state;
    nxt_en    = 1'b0;
    nxt_val   = WB_Value;
    nxt_dest  = WB_Dest;
    cnt_inc   = 1'b0;
    set_err   = 1'b0;
    pend_ld   = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      IDLE: if (mem_valid) begin
        if (!mem_mem_r || dmem_rvalid) begin
          nxt_en   = mem_wb_en;
          nxt_val  = mem_mem_r ? dmem_rdata : mem_alu_res;
          nxt_dest = mem_dest;
          cnt_inc  = 1'b1;
        end else begin
          pend_ld   = 1'b1;
          tmr_load  = 1'b1;
          nxt_state = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        // Data arriving on the expiry cycle still wins over the timeout.
        if (dmem_rvalid) begin
          nxt_en    = pend_wb;
          nxt_val   = dmem_rdata;
          nxt_dest  = pend_dest;
          cnt_inc   = 1'b1;
          nxt_state = IDLE;
        end else if (expired) begin
          set_err   = 1'b1;
          cnt_inc   = 1'b1;
          nxt_state = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign stall = (state == WAIT_LOAD) && !dmem_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      WB_WB_EN    <= 1'b0;
      WB_Value    <= '0;
      WB_Dest     <= '0;
      retired_cnt <= '0;
      timeout_err <= 1'b0;
      pend_dest   <= '0;
      pend_wb     <= 1'b0;
    end else begin
      state    <= nxt_state;
      WB_WB_EN <= nxt_en;
      WB_Value <= nxt_val;
      WB_Dest  <= nxt_dest;
      if (cnt_inc) retired_cnt <= retired_cnt + 1'b1;
      if (set_err) timeout_err <= 1'b1;
      if (pend_ld) begin
        pend_dest <= mem_dest;
        pend_wb   <= mem_wb_en;
      end
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboarded bench for wb_stage: directed ALU/load/timeout/reset/wrap vectors.
module tb_wb_stage;
  localparam int DATA_W = 32, REG_AW = 4, TIMEOUT = 4, CNT_W = 4;

  logic              clk = 1'b0, rst = 1'b0;
  logic              mem_valid = 0, mem_wb_en = 0, mem_mem_r = 0, dmem_rvalid = 0;
  logic [REG_AW-1:0] mem_dest = '0;
  logic [DATA_W-1:0] mem_alu_res = '0, dmem_rdata = '0;
  logic              WB_WB_EN, stall, timeout_err;
  logic [DATA_W-1:0] WB_Value;
  logic [REG_AW-1:0] WB_Dest;
  logic [CNT_W-1:0]  retired_cnt;

  int n_chk = 0, n_fail = 0;
  logic [REG_AW+DATA_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_wb_en(mem_wb_en),
    .mem_mem_r(mem_mem_r), .mem_dest(mem_dest), .mem_alu_res(mem_alu_res),
    .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid), .WB_WB_EN(WB_WB_EN),
    .WB_Value(WB_Value), .WB_Dest(WB_Dest), .stall(stall),
    .retired_cnt(retired_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && WB_WB_EN) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_write: got r%0d=%0h, expected no write", WB_Dest, WB_Value);
      end else begin
        logic [REG_AW+DATA_W-1:0] e;
        e = exp_q.pop_front();
        chk("wb_dest", 64'(WB_Dest), 64'(e[REG_AW+DATA_W-1:DATA_W]));
        chk("wb_value", 64'(WB_Value), 64'(e[DATA_W-1:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    mem_valid = 0; mem_wb_en = 0; mem_mem_r = 0; dmem_rvalid = 0;
  endtask

  task automatic issue(input logic ld, input logic rv, input logic [REG_AW-1:0] d,
                       input logic [DATA_W-1:0] v);
    mem_valid = 1; mem_wb_en = 1; mem_mem_r = ld; mem_dest = d;
    mem_alu_res = v; dmem_rdata = v; dmem_rvalid = rv;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_stall"}, 64'(stall), 64'(0));
    chk({tag, "_cnt"}, 64'(retired_cnt), 64'(exp_cnt));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 64'(WB_WB_EN), 0);
    chk("rst_value", 64'(WB_Value), 0);
    chk("rst_dest", 64'(WB_Dest), 0);
    chk("rst_stall", 64'(stall), 0);
    chk("rst_cnt", 64'(retired_cnt), 0);
    chk("rst_err", 64'(timeout_err), 0);
    cyc(); rst = 1; cyc();

    // ALU retire
    issue(0, 0, 3, 32'h0000_00AA); exp_q.push_back({4'd3, 32'h0000_00AA}); exp_cnt++;
    #1 chk("alu_stall", 64'(stall), 0);
    cyc(); idle_in(); cyc();
    check_regs("alu");

    // Zero-wait load
    issue(1, 1, 5, 32'hDEAD_BEEF); exp_q.push_back({4'd5, 32'hDEAD_BEEF}); exp_cnt++;
    #1 chk("zw_stall", 64'(stall), 0);
    cyc(); idle_in(); cyc();
    check_regs("zw");

    // 3-cycle load; MEM traffic during the wait must be ignored
    issue(1, 0, 7, 32'h0);
    #1 chk("ld3_req_stall", 64'(stall), 0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      issue(0, 0, 9, 32'hFFFF);
      #1 chk("ld3_wait_stall", 64'(stall), 1);
      cyc();
    end
    idle_in(); dmem_rvalid = 1; dmem_rdata = 32'h1234;
    exp_q.push_back({4'd7, 32'h1234}); exp_cnt++;
    #1 chk("ld3_rv_stall", 64'(stall), 0);
    cyc(); idle_in(); cyc();
    check_regs("ld3");

    // Timeout: no data ever arrives, write dropped, instruction still counted
    issue(1, 0, 2, 32'h0);
    cyc(); idle_in();
    for (int i = 0; i < TIMEOUT; i++) begin
      #1 chk("to_stall", 64'(stall), 1);
      chk("to_err_pre", 64'(timeout_err), 0);
      cyc();
    end
    exp_cnt++;
    chk("to_err", 64'(timeout_err), 1);
    check_regs("to");
    dmem_rvalid = 1; dmem_rdata = 32'hBAD0;
    #1 chk("to_late_stall", 64'(stall), 0);
    cyc(); idle_in(); cyc();
    chk("to_err_sticky", 64'(timeout_err), 1);
    check_regs("to_late");

    // Reset while a load is outstanding
    issue(0, 0, 4, 32'h55); exp_q.push_back({4'd4, 32'h55}); exp_cnt++;
    cyc();
    issue(1, 0, 6, 32'h0);
    cyc(); idle_in();
    #1 chk("mr_stall_pre", 64'(stall), 1);
    #1 rst = 0;
    #1;
    exp_cnt = '0;
    chk("mr_en", 64'(WB_WB_EN), 0);
    chk("mr_value", 64'(WB_Value), 0);
    chk("mr_dest", 64'(WB_Dest), 0);
    chk("mr_err", 64'(timeout_err), 0);
    check_regs("mr");
    cyc(); rst = 1;
    dmem_rvalid = 1; dmem_rdata = 32'hCAFE;
    #1 chk("mr_rv_stall", 64'(stall), 0);
    cyc(); idle_in(); cyc();
    check_regs("mr_after");

    // Counter wrap: 17 back-to-back ALU retires on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      issue(0, 0, REG_AW'(i), 32'h100 + 32'(i));
      exp_q.push_back({REG_AW'(i), 32'h100 + 32'(i)}); exp_cnt++;
      cyc();
    end
    idle_in(); cyc(); cyc();
    chk("wrap_cnt", 64'(retired_cnt), 64'(1));
    check_regs("wrap");
    chk("queue_drained", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the register-file write port that the decode stage consumes: WB_WB_EN, WB_Value, WB_Dest.
- Takes retiring instructions from the MEM stage and registers them onto the write port.
- ALU results retire in one cycle. Loads wait on a variable-latency data-memory read response, and the block stalls the upstream pipeline meanwhile.
- Also provides a retired-instruction counter and a sticky load-timeout error.

Parameters:
DATA_W, 32, data/result width
REG_AW, 4, register address width (16 registers)
TIMEOUT, 16, max WAIT_LOAD cycles before abort (>=1)
CNT_W, 32, retired-instruction counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
mem_valid  input  1  MEM stage presents a retiring instruction this cycle
mem_wb_en  input  1  instruction writes a register
mem_mem_r  input  1  instruction is a load
mem_dest  input  REG_AW  destination register
mem_alu_res  input  DATA_W  ALU result
dmem_rdata  input  DATA_W  load data
dmem_rvalid  input  1  load data valid (single-cycle pulse)
WB_WB_EN  output  1  register-file write enable, to decode stage
WB_Value  output  DATA_W  write data
WB_Dest  output  REG_AW  write address
stall  output  1  freeze MEM and earlier stages
retired_cnt  output  CNT_W  retired instructions, wraps modulo 2^CNT_W
timeout_err  output  1  sticky load-timeout flag

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - WB_WB_EN=0, WB_Value=0, WB_Dest=0.
  - retired_cnt=0, timeout_err=0, wait counter=0.
  - Pending registers cleared.
  - stall=0 during reset.
  - Reset mid-WAIT_LOAD abandons the load silently; a later dmem_rvalid in IDLE is ignored.
- Outputs WB_* are registered. WB_WB_EN is high for exactly one cycle per retired writing instruction.
- State IDLE:
  - mem_valid & ~mem_mem_r: next edge drives WB_WB_EN<=mem_wb_en, WB_Value<=mem_alu_res, WB_Dest<=mem_dest; retired_cnt+1. Latency 1 cycle.
  - mem_valid & mem_mem_r & dmem_rvalid (zero-wait load): next edge drives WB_WB_EN<=mem_wb_en, WB_Value<=dmem_rdata, WB_Dest<=mem_dest; retired_cnt+1; stay IDLE.
  - mem_valid & mem_mem_r & ~dmem_rvalid: latch pend_dest<=mem_dest, pend_wb<=mem_wb_en; wait counter<=1; go WAIT_LOAD; WB_WB_EN<=0.
  - ~mem_valid: WB_WB_EN<=0; WB_Value and WB_Dest hold.
  - dmem_rvalid without a load request: ignored.
- State WAIT_LOAD:
  - stall = 1 & ~dmem_rvalid (combinational). Upstream advances in the cycle the data arrives.
  - mem_valid and other MEM inputs are ignored (upstream is frozen).
  - dmem_rvalid: next edge drives WB_WB_EN<=pend_wb, WB_Value<=dmem_rdata, WB_Dest<=pend_dest; retired_cnt+1; go IDLE.
  - Else if wait counter==TIMEOUT: timeout_err<=1; WB_WB_EN<=0 (write dropped); retired_cnt+1; go IDLE. stall stays 1 in this cycle and drops the next cycle.
  - Else wait counter+1.
  - dmem_rvalid in the same cycle as the timeout condition: data wins, no error.
- In IDLE, stall=0 always.
- timeout_err is cleared only by reset.
- retired_cnt wraps all-ones -> 0 with no flag.
- Wait counter width: $clog2(TIMEOUT+1).

Decomposition:
- Package wb_pkg holds:
  - enum wb_state_t {IDLE, WAIT_LOAD}
  - constants DATA_W_DEF=32, REG_AW_DEF=4
- One sub-module, wb_wait_timer:
  - Inputs: clear/load-1, enable.
  - Output: expired flag when count==TIMEOUT.
  - Same async active-low reset.
- FSM, mux and output registers stay in wb_stage.

Test Plan:
- ALU retire: reset release; mem_valid=1, mem_wb_en=1, dest=3, alu_res=0x0000_00AA for 1 cycle -> next cycle WB_WB_EN=1, WB_Dest=3, WB_Value=0xAA; following cycle WB_WB_EN=0; retired_cnt=1; stall never high.
- Zero-wait load: mem_mem_r=1, dest=5, dmem_rvalid=1, rdata=0xDEAD_BEEF same cycle -> next cycle WB_WB_EN=1, WB_Dest=5, WB_Value=0xDEADBEEF; stall=0 throughout.
- 3-cycle load: request dest=7, rvalid arrives 3 cycles later with rdata=0x1234 -> stall=1 for the 2 intervening cycles and 0 in the rvalid cycle; WB write of 0x1234 to r7 the cycle after rvalid; mem_valid pulses during the wait produce no writes.
- Timeout: TIMEOUT=4, load to dest=2, never assert rvalid -> stall high 4 cycles; timeout_err=1 after the 4th wait cycle; no WB_WB_EN pulse; retired_cnt+1; late rvalid then ignored; timeout_err stays 1 until rst=0.
- Reset mid-wait: assert rst=0 asynchronously (between edges) while in WAIT_LOAD -> all outputs 0 immediately; after release, an rvalid pulse yields no write and stall=0.
- Counter wrap: CNT_W=4, retire 17 ALU instructions back-to-back -> retired_cnt reads 1; one WB_WB_EN pulse per instruction with correct dest and data each cycle.
